// File: rtl/cpu_core_pkg.sv
// rtl/cpu_core_pkg.sv - opcode/funct constants and ALU encoding for cpu_core
package cpu_core_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [2:0] F3_ADD  = 3'd0;
  localparam logic [2:0] F3_SLL  = 3'd1;
  localparam logic [2:0] F3_SLT  = 3'd2;
  localparam logic [2:0] F3_SLTU = 3'd3;
  localparam logic [2:0] F3_XOR  = 3'd4;
  localparam logic [2:0] F3_SR   = 3'd5;
  localparam logic [2:0] F3_OR   = 3'd6;
  localparam logic [2:0] F3_AND  = 3'd7;

  localparam logic [2:0] F3_BEQ  = 3'd0;
  localparam logic [2:0] F3_BNE  = 3'd1;
  localparam logic [2:0] F3_BLT  = 3'd4;
  localparam logic [2:0] F3_BGE  = 3'd5;
  localparam logic [2:0] F3_BLTU = 3'd6;
  localparam logic [2:0] F3_BGEU = 3'd7;
  localparam logic [2:0] F3_WORD = 3'd2;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
    ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS_B
  } alu_op_e;

  typedef enum logic [1:0] {WB_ALU, WB_LINK, WB_MEM} wb_sel_e;

  // alt selects SUB/SRA; callers only raise it where the encoding allows it
  function automatic alu_op_e f_alu_op(input logic [2:0] funct3, input logic alt);
    alu_op_e op;
    case (funct3)
      F3_ADD:  op = alt ? ALU_SUB : ALU_ADD;
      F3_SLL:  op = ALU_SLL;
      F3_SLT:  op = ALU_SLT;
      F3_SLTU: op = ALU_SLTU;
      F3_XOR:  op = ALU_XOR;
      F3_SR:   op = alt ? ALU_SRA : ALU_SRL;
      F3_OR:   op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/cpu_regfile.sv
// rtl/cpu_regfile.sv - 32x32 register file, two async reads, one sync write, x0 hardwired
module cpu_regfile (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [4:0]  i_rs1_addr,
  input  logic [4:0]  i_rs2_addr,
  output logic [31:0] o_rs1_data,
  output logic [31:0] o_rs2_data,
  input  logic        i_we,
  input  logic [4:0]  i_rd_addr,
  input  logic [31:0] i_rd_data
);
  logic [31:0] r_regs [32];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= '0;
    end else if (i_we && (i_rd_addr != 5'd0)) begin
      r_regs[i_rd_addr] <= i_rd_data;
    end
  end

  assign o_rs1_data = (i_rs1_addr == 5'd0) ? '0 : r_regs[i_rs1_addr];
  assign o_rs2_data = (i_rs2_addr == 5'd0) ? '0 : r_regs[i_rs2_addr];
endmodule

// File: rtl/cpu_core.sv
// rtl/cpu_core.sv - single-cycle RV32I-subset core with internal ROM and data RAM
module cpu_core
  import cpu_core_pkg::*;
#(
  parameter int    IMEM_WORDS   = 64,
  parameter int    DMEM_WORDS   = 64,
  parameter string PROGRAM_FILE = "program.hex"
) (
  input  logic        clock,
  input  logic        reset,
  output logic [5:0]  led,
  output logic [31:0] result
);
  localparam int IW = (IMEM_WORDS > 1) ? $clog2(IMEM_WORDS) : 1;
  localparam int DW = (DMEM_WORDS > 1) ? $clog2(DMEM_WORDS) : 1;

  localparam int DEF_WORDS = 5;
  localparam logic [31:0] DEF_PROG [DEF_WORDS] = '{
    32'h00100093, 32'h00200113, 32'h002081B3, 32'h00318233, 32'h0000006F
  };

  logic [31:0] r_pc, r_result;
  logic [31:0] r_imem [IMEM_WORDS];
  logic [31:0] r_dmem [DMEM_WORDS];

  // Unlisted words stay NOP so a short image runs into harmless fill
  initial begin : rom_init
    for (int i = 0; i < IMEM_WORDS; i++) r_imem[i] = NOP_WORD;
    if (PROGRAM_FILE != "") begin
      for (int i = 0; i < DEF_WORDS && i < IMEM_WORDS; i++) r_imem[i] = DEF_PROG[i];
    end
  end

  logic [IW-1:0] w_iidx;
  logic [DW-1:0] w_didx;
  logic [31:0]   w_instr, w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
  logic [6:0]    w_opcode, w_f7;
  logic [4:0]    w_rd, w_rs1, w_rs2;
  logic [2:0]    w_f3;
  logic [31:0]   w_rs1_data, w_rs2_data, w_pc_plus4, w_mem_addr, w_dmem_rdata;
  logic [31:0]   w_alu_a, w_alu_b, w_alu_y, w_next_pc, w_wdata;
  logic          w_taken, w_rf_we, w_dmem_we, w_unused;
  alu_op_e       w_alu_op;
  wb_sel_e       w_wb_sel;

  assign w_iidx   = IW'(r_pc[31:2] % 30'(IMEM_WORDS));
  assign w_instr  = r_imem[w_iidx];
  assign w_opcode = w_instr[6:0];
  assign w_rd     = w_instr[11:7];
  assign w_f3     = w_instr[14:12];
  assign w_rs1    = w_instr[19:15];
  assign w_rs2    = w_instr[24:20];
  assign w_f7     = w_instr[31:25];
  assign w_imm_i  = {{20{w_instr[31]}}, w_instr[31:20]};
  assign w_imm_s  = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
  assign w_imm_b  = {{19{w_instr[31]}}, w_instr[31], w_instr[7], w_instr[30:25], w_instr[11:8], 1'b0};
  assign w_imm_u  = {w_instr[31:12], 12'b0};
  assign w_imm_j  = {{11{w_instr[31]}}, w_instr[31], w_instr[19:12], w_instr[20], w_instr[30:21], 1'b0};

  cpu_regfile u_regfile (
    .i_clk      (clock),
    .i_reset    (reset),
    .i_rs1_addr (w_rs1),
    .i_rs2_addr (w_rs2),
    .o_rs1_data (w_rs1_data),
    .o_rs2_data (w_rs2_data),
    .i_we       (w_rf_we),
    .i_rd_addr  (w_rd),
    .i_rd_data  (w_wdata)
  );

  // One adder serves load/store addressing and the JALR target
  assign w_pc_plus4   = r_pc + 32'd4;
  assign w_mem_addr   = w_rs1_data + ((w_opcode == OP_STORE) ? w_imm_s : w_imm_i);
  assign w_didx       = DW'(w_mem_addr[31:2] % 30'(DMEM_WORDS));
  assign w_dmem_rdata = r_dmem[w_didx];
  assign w_unused     = w_mem_addr[0];

  always_comb begin
    w_alu_y = '0;
    case (w_alu_op)
      ALU_ADD:    w_alu_y = w_alu_a + w_alu_b;
      ALU_SUB:    w_alu_y = w_alu_a - w_alu_b;
      ALU_SLL:    w_alu_y = w_alu_a << w_alu_b[4:0];
      ALU_SLT:    w_alu_y = {31'b0, $signed(w_alu_a) < $signed(w_alu_b)};
      ALU_SLTU:   w_alu_y = {31'b0, w_alu_a < w_alu_b};
      ALU_XOR:    w_alu_y = w_alu_a ^ w_alu_b;
      ALU_SRL:    w_alu_y = w_alu_a >> w_alu_b[4:0];
      ALU_SRA:    w_alu_y = $unsigned($signed(w_alu_a) >>> w_alu_b[4:0]);
      ALU_OR:     w_alu_y = w_alu_a | w_alu_b;
      ALU_AND:    w_alu_y = w_alu_a & w_alu_b;
      ALU_PASS_B: w_alu_y = w_alu_b;
      default:    w_alu_y = '0;
    endcase
  end

  always_comb begin
    w_taken = 1'b0;
    case (w_f3)
      F3_BEQ:  w_taken = (w_rs1_data == w_rs2_data);
      F3_BNE:  w_taken = (w_rs1_data != w_rs2_data);
      F3_BLT:  w_taken = ($signed(w_rs1_data) < $signed(w_rs2_data));
      F3_BGE:  w_taken = ($signed(w_rs1_data) >= $signed(w_rs2_data));
      F3_BLTU: w_taken = (w_rs1_data < w_rs2_data);
      F3_BGEU: w_taken = (w_rs1_data >= w_rs2_data);
      default: w_taken = 1'b0;
    endcase
  end

  // Anything not decoded below falls out as a NOP: pc+4, no writes
  always_comb begin
    w_alu_op  = ALU_ADD;
    w_alu_a   = w_rs1_data;
    w_alu_b   = w_imm_i;
    w_rf_we   = 1'b0;
    w_wb_sel  = WB_ALU;
    w_dmem_we = 1'b0;
    w_next_pc = w_pc_plus4;
    case (w_opcode)
      OP_LUI: begin
        w_rf_we  = 1'b1;
        w_alu_op = ALU_PASS_B;
        w_alu_b  = w_imm_u;
      end
      OP_AUIPC: begin
        w_rf_we = 1'b1;
        w_alu_a = r_pc;
        w_alu_b = w_imm_u;
      end
      OP_JAL: begin
        w_rf_we   = 1'b1;
        w_wb_sel  = WB_LINK;
        w_next_pc = r_pc + w_imm_j;
      end
      OP_JALR: if (w_f3 == F3_ADD) begin
        w_rf_we   = 1'b1;
        w_wb_sel  = WB_LINK;
        w_next_pc = {w_mem_addr[31:1], 1'b0};
      end
      OP_BRANCH: if (w_taken) w_next_pc = r_pc + w_imm_b;
      OP_LOAD: if (w_f3 == F3_WORD) begin
        w_rf_we  = 1'b1;
        w_wb_sel = WB_MEM;
      end
      OP_STORE: w_dmem_we = (w_f3 == F3_WORD);
      OP_IMM: begin
        w_rf_we  = (w_f3 == F3_SLL) ? (w_f7 == F7_BASE)
                 : (w_f3 == F3_SR)  ? (w_f7 == F7_BASE || w_f7 == F7_ALT) : 1'b1;
        w_alu_op = f_alu_op(w_f3, (w_f3 == F3_SR) && w_f7[5]);
      end
      OP_REG: begin
        w_rf_we  = (w_f7 == F7_BASE) ||
                   ((w_f7 == F7_ALT) && (w_f3 == F3_ADD || w_f3 == F3_SR));
        w_alu_op = f_alu_op(w_f3, w_f7[5]);
        w_alu_b  = w_rs2_data;
      end
      default: ;
    endcase
  end

  always_comb begin
    case (w_wb_sel)
      WB_LINK: w_wdata = w_pc_plus4;
      WB_MEM:  w_wdata = w_dmem_rdata;
      default: w_wdata = w_alu_y;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_pc     <= '0;
      r_result <= '0;
    end else begin
      r_pc <= w_next_pc;
      if (w_rf_we && (w_rd != 5'd0)) r_result <= w_wdata;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && w_dmem_we) r_dmem[w_didx] <= w_rs2_data;
  end

  assign result = r_result;
  assign led    = ~r_result[5:0];
endmodule

// File: tb/tb_cpu_core.sv
// tb/tb_cpu_core.sv - scoreboard bench for cpu_core with directed programs
module tb_cpu_core;
  localparam int K_RES = 0, K_LED = 1, K_PC = 2, K_REG = 3, K_MEM = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [5:0]  led;
  logic [31:0] result;

  cpu_core #(.IMEM_WORDS(64), .DMEM_WORDS(64), .PROGRAM_FILE("")) dut (
    .clock  (clock),
    .reset  (reset),
    .led    (led),
    .result (result)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    int          kind;
    int          idx;
    logic [31:0] val;
    int          tid;
  } exp_t;

  exp_t        q[$];
  logic [31:0] prog[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          test_id  = 0;

  function automatic logic [31:0] i_t(int imm, int rs1, int f3, int rd, int op);
    logic [31:0] m, a, f, d, o;
    m = imm; a = rs1; f = f3; d = rd; o = op;
    return {m[11:0], a[4:0], f[2:0], d[4:0], o[6:0]};
  endfunction

  function automatic logic [31:0] r_t(int f7, int rs2, int rs1, int f3, int rd);
    logic [31:0] s, b, a, f, d;
    s = f7; b = rs2; a = rs1; f = f3; d = rd;
    return {s[6:0], b[4:0], a[4:0], f[2:0], d[4:0], 7'h33};
  endfunction

  function automatic logic [31:0] s_t(int imm, int rs2, int rs1);
    logic [31:0] m, b, a;
    m = imm; b = rs2; a = rs1;
    return {m[11:5], b[4:0], a[4:0], 3'd2, m[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] b_t(int imm, int rs2, int rs1, int f3);
    logic [31:0] m, b, a, f;
    m = imm; b = rs2; a = rs1; f = f3;
    return {m[12], m[10:5], b[4:0], a[4:0], f[2:0], m[4:1], m[11], 7'h63};
  endfunction

  function automatic logic [31:0] j_t(int rd, int imm);
    logic [31:0] m, d;
    m = imm; d = rd;
    return {m[20], m[10:1], m[11], m[19:12], d[4:0], 7'h6F};
  endfunction

  function automatic string kname(int k);
    case (k)
      K_RES:   return "result";
      K_LED:   return "led";
      K_PC:    return "pc";
      K_REG:   return "reg";
      default: return "dmem";
    endcase
  endfunction

  function automatic logic [31:0] actual(int k, int idx);
    case (k)
      K_RES:   return result;
      K_LED:   return {26'b0, led};
      K_PC:    return dut.r_pc;
      K_REG:   return dut.u_regfile.r_regs[idx];
      default: return dut.r_dmem[idx];
    endcase
  endfunction

  task automatic chk(input int after, input int kind, input int idx, input logic [31:0] val);
    exp_t e;
    e.cyc = cyc + after; e.kind = kind; e.idx = idx; e.val = val; e.tid = test_id;
    q.push_back(e);
  endtask

  // Monitor: compares every expectation whose edge count has been reached
  exp_t        mon_e;
  logic [31:0] mon_act;
  always @(negedge clock) begin
    #1;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      mon_e   = q.pop_front();
      mon_act = actual(mon_e.kind, mon_e.idx);
      n_checks++;
      if (mon_act !== mon_e.val) begin
        n_errors++;
        $display("FAIL t%0d %s[%0d] @%0d: got %h expected %h",
                 mon_e.tid, kname(mon_e.kind), mon_e.idx, mon_e.cyc, mon_act, mon_e.val);
      end
    end
  end

  task automatic start_test(input int t);
    test_id = t;
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 64; i++) dut.r_imem[i] = (i < prog.size()) ? prog[i] : 32'h0000_0013;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (q.size() > 0 && k < 200) begin
      @(negedge clock);
      #2;
      k++;
    end
    if (q.size() > 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL t%0d drain: %0d expectations pending, required 0", test_id, q.size());
      q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Default program: reset state, then halt at pc 16 with result 6
    prog = '{32'h00100093, 32'h00200113, 32'h002081B3, 32'h00318233, 32'h0000006F};
    start_test(1);
    chk(0, K_RES, 0, 32'd0);
    chk(0, K_LED, 0, 32'h3F);
    chk(0, K_PC, 0, 32'd0);
    chk(3, K_RES, 0, 32'd3);
    chk(20, K_RES, 0, 32'd6);
    chk(20, K_REG, 4, 32'd6);
    chk(20, K_LED, 0, 32'h39);
    chk(20, K_PC, 0, 32'd16);
    drain();

    // Reset mid-run after two instructions
    start_test(2);
    chk(2, K_REG, 1, 32'd1);
    chk(2, K_REG, 2, 32'd2);
    chk(2, K_RES, 0, 32'd2);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    chk(1, K_PC, 0, 32'd0);
    chk(1, K_RES, 0, 32'd0);
    chk(1, K_REG, 1, 32'd0);
    chk(1, K_REG, 2, 32'd0);
    chk(1, K_LED, 0, 32'h3F);
    @(negedge clock);
    reset = 1'b0;
    drain();

    // Shifts and signed/unsigned compares
    prog = '{i_t(-1, 0, 0, 5, 'h13), i_t(28, 5, 5, 6, 'h13), i_t('h400 | 28, 5, 5, 7, 'h13),
             r_t(0, 5, 0, 3, 8), r_t(0, 0, 5, 2, 9), j_t(0, 0)};
    start_test(3);
    chk(6, K_REG, 5, 32'hFFFF_FFFF);
    chk(6, K_REG, 6, 32'd15);
    chk(6, K_REG, 7, 32'hFFFF_FFFF);
    chk(6, K_REG, 8, 32'd1);
    chk(6, K_REG, 9, 32'd1);
    chk(6, K_RES, 0, 32'd1);
    chk(6, K_LED, 0, 32'h3E);
    drain();

    // Store/load, ignored low address bits, address wrap, store leaves result
    prog = '{i_t(42, 0, 0, 1, 'h13), s_t(8, 1, 0), i_t(11, 0, 2, 2, 'h03),
             s_t(12, 0, 0), i_t(264, 0, 2, 5, 'h03), j_t(0, 0)};
    start_test(4);
    chk(3, K_REG, 2, 32'd42);
    chk(3, K_RES, 0, 32'd42);
    chk(3, K_MEM, 2, 32'd42);
    chk(4, K_MEM, 3, 32'd0);
    chk(4, K_RES, 0, 32'd42);
    chk(5, K_REG, 5, 32'd42);
    drain();

    // Taken bne skips one instruction, untaken beq falls through
    prog = '{i_t(3, 0, 0, 1, 'h13), b_t(8, 0, 1, 1), i_t(9, 0, 0, 2, 'h13), i_t(7, 0, 0, 3, 'h13),
             b_t(8, 0, 1, 0), i_t(11, 0, 0, 4, 'h13), j_t(0, 0)};
    start_test(5);
    chk(2, K_PC, 0, 32'd12);
    chk(10, K_REG, 2, 32'd0);
    chk(10, K_REG, 3, 32'd7);
    chk(10, K_REG, 4, 32'd11);
    chk(10, K_RES, 0, 32'd11);
    chk(10, K_PC, 0, 32'd24);
    drain();

    // x0 write, illegal word, then fetch wraps after 64 words
    prog = '{i_t(5, 1, 0, 1, 'h13), i_t(5, 0, 0, 0, 'h13), 32'hFFFF_FFFF};
    start_test(6);
    chk(1, K_RES, 0, 32'd5);
    chk(2, K_PC, 0, 32'd8);
    chk(2, K_REG, 0, 32'd0);
    chk(2, K_RES, 0, 32'd5);
    chk(3, K_PC, 0, 32'd12);
    chk(3, K_RES, 0, 32'd5);
    chk(4, K_PC, 0, 32'd16);
    chk(64, K_PC, 0, 32'd256);
    chk(65, K_REG, 1, 32'd10);
    chk(65, K_RES, 0, 32'd10);
    chk(65, K_PC, 0, 32'd260);
    drain();

    // LUI, AUIPC, JAL/JALR links and targets, SUB
    prog = '{32'h123450B7, 32'h00001117, j_t(3, 8), i_t(99, 0, 0, 9, 'h13),
             i_t(29, 0, 0, 5, 'h13), i_t(3, 5, 0, 6, 'h67), i_t(99, 0, 0, 9, 'h13),
             i_t(99, 0, 0, 9, 'h13), r_t('h20, 2, 1, 0, 7), j_t(0, 0)};
    start_test(7);
    chk(3, K_PC, 0, 32'd16);
    chk(5, K_PC, 0, 32'd32);
    chk(7, K_REG, 1, 32'h1234_5000);
    chk(7, K_REG, 2, 32'h0000_1004);
    chk(7, K_REG, 3, 32'd12);
    chk(7, K_REG, 6, 32'd24);
    chk(7, K_REG, 9, 32'd0);
    chk(7, K_REG, 7, 32'h1234_3FFC);
    chk(7, K_RES, 0, 32'h1234_3FFC);
    chk(7, K_LED, 0, 32'h03);
    chk(7, K_PC, 0, 32'd36);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/cpu_core.md
Name: cpu_core

Overview:
- Minimal single-cycle RV32I-subset processor for the MC851 FPGA board.
- Fetches from an internal instruction ROM, executes one instruction per clock, and writes to a 32-entry register file and a small word-addressed data RAM.
- Exposes the last written-back value as result and drives the board's 6 LEDs from it.

Parameters:
- IMEM_WORDS, 64, instruction ROM depth in 32-bit words.
- DMEM_WORDS, 64, data RAM depth in 32-bit words.
- PROGRAM_FILE, "program.hex", hex image loaded into ROM at elaboration; words not in the file read as 0x00000013 (NOP).

Ports:
- clock  input  1  single system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- led  output  6  active-low LED drive; equals ~result[5:0].
- result  output  32  value written to rd by the most recent instruction with rd != x0.

Behaviour:
- Reset (sampled at a rising edge while reset=1):
  - pc=0, result=0, so led=6'b111111.
  - All registers x1..x31 = 0; data RAM is not cleared.
- Timing:
  - Single cycle: each rising edge with reset=0 retires exactly one instruction.
  - Writes to pc, rd, result and RAM occur at that edge.
  - Register file: combinational read, synchronous write; x0 always reads 0 and writes to it are discarded.
- Fetch: instr = ROM[pc[31:2]]. pc beyond IMEM_WORDS wraps modulo IMEM_WORDS.
- Supported instructions:
  - LUI, AUIPC, JAL, JALR.
  - BEQ, BNE, BLT, BGE, BLTU, BGEU.
  - LW, SW.
  - ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI.
  - ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND.
- Immediates: sign-extended per RV32I I/S/B/U/J formats. Shift amount = low 5 bits.
- Arithmetic: 32-bit wrap-around, no overflow flag. SLT is signed; SLTU is unsigned.
- Next pc:
  - Default pc+4.
  - Taken branch / JAL: pc+imm.
  - JALR: (rs1+imm) & ~1.
  - JAL/JALR write pc+4 to rd.
- Memory:
  - Address = rs1+imm, word index addr[31:2] modulo DMEM_WORDS; low 2 bits ignored.
  - LW writes RAM word to rd. SW writes rs2 at the edge.
  - Loads read asynchronously.
- result updates whenever an instruction writes an rd != x0, with the value written. Stores, branches and writes to x0 leave it unchanged.
- Unsupported or illegal opcodes execute as NOP: pc+4, no state change.
- Halt idiom: JAL x0,0 loops forever; state is stable.
- reset asserted mid-program takes effect at the next edge and overrides any write of that cycle.

Decomposition:
- Shared package holds:
  - Opcode constants: OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_IMM, OP_REG.
  - funct3/funct7 constants.
  - ALU operation enum.
- One natural sub-module: cpu_regfile, holding 32x32 registers with 2 read ports, 1 write port and hardwired x0.
- Decode, ALU, ROM and RAM stay in cpu_core.

Test Plan:
- Default program (addi x1,x0,1; addi x2,x0,2; add x3,x1,x2; add x4,x3,x3; jal x0,0), reset 1 cycle then 20 cycles -> result=6, x4=6, led=6'b111001, pc stuck at 16.
- Reset mid-run after 2 instructions -> next edge pc=0, result=0, x1=x2=0, led=6'b111111.
- addi x5,x0,-1; srli x6,x5,28; srai x7,x5,28; sltu x8,x0,x5; slt x9,x5,x0 -> x6=15, x7=0xFFFFFFFF, x8=1, x9=1.
- addi x1,x0,42; sw x1,8(x0); lw x2,8(x0) -> x2=42, result=42. A following sw does not change result.
- addi x1,x0,3; bne x1,x0,+8; addi x2,x0,9; addi x3,x0,7 -> x2=0, x3=7. beq with unequal operands falls through.
- addi x0,x0,5 then illegal word 0xFFFFFFFF -> x0 reads 0, result unchanged, pc advances by 4 each cycle.
